sm_regdump_uart: RTL
====================

// Module: sm_regdump_uart
// PURPOSE
//  Reader for the CPU debug register port (regAddr/regData). On a start pulse it
//  walks registers FIRST_REG..LAST_REG, snapshots each value and streams it out
//  over an 8N1 UART TX line as a 5-byte record: index byte, then 32-bit value MSB first.
//  Sits beside sm_cpu at board top level. Gives a host-side register dump without a JTAG probe.
// PARAMETERS
//  CLK_DIV    434  clock cycles per UART bit (50 MHz / 115200); legal range >= 2
//  FIRST_REG  0    first register index dumped (index 0 returns the PC via the debug port)
//  LAST_REG   31   last register index dumped; must satisfy LAST_REG >= FIRST_REG
// PORTS
//  clk      in   1   clock
//  rst_n    in   1   reset, asynchronous, active-low
//  start    in   1   dump request; sampled only while idle
//  regAddr  out  5   debug register address driven to the CPU
//  regData  in   32  debug register data from the CPU (combinational on regAddr)
//  uart_tx  out  1   serial output, idle high
//  busy     out  1   high while a dump is in progress
//  done     out  1   one-cycle pulse when the dump completes
// BEHAVIOUR
//  Reset (async, rst_n=0): uart_tx=1, busy=0, done=0, regAddr=FIRST_REG, FSM=IDLE.
//    All counters are cleared. A reset mid-frame forces uart_tx high immediately, without waiting for a clock.
//  FSM states: IDLE -> ADDR -> LATCH -> START -> DATA -> STOP -> (next byte | next reg | DONE).
//  IDLE: busy=0. When start=1 at a clock edge, go to ADDR and set busy=1. regAddr=FIRST_REG.
//  ADDR: 1 cycle. regAddr is stable so the CPU read path can settle.
//  LATCH: 1 cycle. Capture regData into a 32-bit shadow register. Load byte0 = {3'b000, regAddr}.
//    After capture, changes on regData have no effect on the record being sent.
//  START: uart_tx=0 for CLK_DIV cycles.
//  DATA: 8 bits, LSB first, each held CLK_DIV cycles.
//  STOP: uart_tx=1 for CLK_DIV cycles. Then:
//    - byte count < 4: load the next byte (shadow[31:24], [23:16], [15:8], [7:0], in that order).
//      Go to START with no idle gap.
//    - regAddr < LAST_REG: increment regAddr, go to ADDR.
//    - otherwise: go to DONE.
//  DONE: 1 cycle. done=1, busy=0, regAddr=FIRST_REG, then go to IDLE.
//  Register advance uses an explicit compare against LAST_REG. The 5-bit regAddr never wraps 31->0.
//  Timing per register = 2 + 50*CLK_DIV cycles.
//    busy stays high for (LAST_REG-FIRST_REG+1)*(2+50*CLK_DIV) cycles, starting from the edge that samples start.
//  start is ignored while busy=1 and during the DONE cycle. The earliest restart is the first IDLE cycle.
//  Bit counter: ceil(log2(CLK_DIV)) bits, reloaded at every bit boundary. No accumulated drift.
//  Consistency: each register is snapshotted individually. The dump is not atomic across registers while the CPU runs.
//  uart_tx is a registered output (glitch-free). busy and done are registered outputs.
// TESTING
//  1 CLK_DIV=4, FIRST=LAST=5, regData=0xDEADBEEF at addr 5, pulse start
//    -> tx frames 0x05,0xDE,0xAD,0xBE,0xEF.
//    -> each bit lasts exactly 4 cycles; busy is high for 202 cycles; one done pulse.
//  2 Full dump (0..31), CLK_DIV=4, model regData=addr*0x01010101 with PC=0x00000010 at addr 0
//    -> 160 bytes; record r = {r, r,r,r,r}; record 0 value = 0x00000010.
//  3 Pulse start again at cycles 10 and 100 of an active dump
//    -> no restart and no extra bytes. A start on the first idle cycle after done begins a new dump.
//  4 Assert rst_n=0 mid-bit of the third byte
//    -> uart_tx=1, busy=0 and regAddr=FIRST_REG with no clock edge needed.
//    -> a later start produces a complete, correct dump.
//  5 Change regData on every cycle after LATCH
//    -> the transmitted value equals the value present during the LATCH cycle.
//  6 CLK_DIV=2 (minimum), single register 0x80000001
//    -> correct 8N1 decode; start and stop bits are each exactly 2 cycles; no gap between frames.

Source files
------------

// File: rtl/sm_regdump_uart_if.sv
// Debug register port between the CPU and a register reader.
// The reader drives the address; the CPU returns data combinationally.
interface sm_regdump_uart_if;
  logic [4:0]  regAddr;
  logic [31:0] regData;

  modport master (output regAddr, input regData);
  modport slave  (input regAddr, output regData);
endinterface

// File: rtl/sm_regdump_uart.sv
// Walks FIRST_REG..LAST_REG on the debug port and sends each as a 5-byte 8N1 record.
// Each register takes 2 + 50*CLK_DIV cycles. start is ignored until the FSM is back in IDLE.
module sm_regdump_uart #(
  parameter int CLK_DIV   = 434,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  sm_regdump_uart_if.master         dbg,
  output logic                      uart_tx,
  output logic                      busy,
  output logic                      done
);

  localparam int              TW       = $clog2(CLK_DIV);
  localparam logic [TW-1:0]   BIT_LAST = TW'(CLK_DIV - 1);
  localparam logic [4:0]      FIRST    = 5'(FIRST_REG);
  localparam logic [4:0]      LAST     = 5'(LAST_REG);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LATCH,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t          state;
  logic [4:0]      addr;
  logic [31:0]     shadow;
  logic [7:0]      shiftReg;
  logic [TW-1:0]   bitTimer;
  logic [2:0]      bitCnt;
  logic [2:0]      byteCnt;
  logic            bitEnd;

  assign dbg.regAddr = addr;
  assign bitEnd      = (bitTimer == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= FIRST;
      shadow   <= '0;
      shiftReg <= '0;
      bitTimer <= '0;
      bitCnt   <= '0;
      byteCnt  <= '0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ADDR;
            busy  <= 1'b1;
            addr  <= FIRST;
          end
        end

        ADDR: state <= LATCH;

        LATCH: begin
          shadow   <= dbg.regData;
          shiftReg <= {3'b000, addr};
          byteCnt  <= '0;
          bitTimer <= BIT_LAST;
          uart_tx  <= 1'b0;
          state    <= START;
        end

        START: begin
          if (bitEnd) begin
            bitTimer <= BIT_LAST;
            uart_tx  <= shiftReg[0];
            shiftReg <= {1'b0, shiftReg[7:1]};
            bitCnt   <= '0;
            state    <= DATA;
          end else begin
            bitTimer <= bitTimer - 1'b1;
          end
        end

        DATA: begin
          if (bitEnd) begin
            bitTimer <= BIT_LAST;
            if (bitCnt == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              uart_tx  <= shiftReg[0];
              shiftReg <= {1'b0, shiftReg[7:1]};
              bitCnt   <= bitCnt + 1'b1;
            end
          end else begin
            bitTimer <= bitTimer - 1'b1;
          end
        end

        STOP: begin
          if (bitEnd) begin
            if (byteCnt < 3'd4) begin
              // Value bytes leave MSB first; shadow shifts up so [31:24] is always next.
              shiftReg <= shadow[31:24];
              shadow   <= {shadow[23:0], 8'h00};
              byteCnt  <= byteCnt + 1'b1;
              bitTimer <= BIT_LAST;
              uart_tx  <= 1'b0;
              state    <= START;
            end else if (addr < LAST) begin
              addr  <= addr + 1'b1;
              state <= ADDR;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              addr  <= FIRST;
              state <= DONE;
            end
          end else begin
            bitTimer <= bitTimer - 1'b1;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
